gcn_combination: RTL and testbench

- Downstream neighbour of the feature×weight transformation stage.
- After transformation completes, this block walks a COO adjacency edge list and reads the stored FM×WM product rows by row index.
- It accumulates neighbour rows, adds a self-loop, and produces a per-node class label by argmax.
- Its outputs are the final GCN node classifications.

---
 rtl/gcn_combination_if.sv | 30 +++
 rtl/gcn_combination.sv | 167 ++++++++++++++++
 tb/tb_gcn_combination.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gcn_combination_if.sv
// gcn_combination_if: control, COO memory and product-row bus of the GCN combination stage
interface gcn_combination_if #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int COO_ADDRESS_WIDTH = 13,
    parameter int ROW_WIDTH         = $clog2(FEATURE_ROWS),
    parameter int LABEL_WIDTH       = $clog2(WEIGHT_COLS)
);
    logic                                  start;
    logic [2*ROW_WIDTH-1:0]                coo_in;
    logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row;
    logic [COO_ADDRESS_WIDTH-1:0]          coo_address;
    logic [ROW_WIDTH-1:0]                  read_row;
    logic                                  coo_read_enable;
    logic [FEATURE_ROWS*LABEL_WIDTH-1:0]   y;
    logic                                  busy;
    logic                                  coo_error;
    logic                                  done;

    modport master (
        output start, coo_in, fm_wm_row,
        input  coo_address, read_row, coo_read_enable, y, busy, coo_error, done
    );

    modport slave (
        input  start, coo_in, fm_wm_row,
        output coo_address, read_row, coo_read_enable, y, busy, coo_error, done
    );
endinterface

// File: rtl/gcn_combination.sv
// gcn_combination: aggregates neighbour product rows over a COO edge list, adds self-loops, labels nodes by argmax
module gcn_combination #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int NUM_EDGES         = 6,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int AGG_WIDTH         = 21,
    parameter int COO_ADDRESS_WIDTH = 13,
    parameter int ROW_WIDTH         = $clog2(FEATURE_ROWS),
    parameter int LABEL_WIDTH       = $clog2(WEIGHT_COLS)
) (
    input logic               clk,
    input logic               reset,
    gcn_combination_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC_DST, S_ACC_SRC, S_SELF, S_ARGMAX, S_DONE} state_t;

    state_t                       r_state;
    logic [COO_ADDRESS_WIDTH-1:0] r_edge_idx;
    logic [ROW_WIDTH-1:0]         r_node;
    logic [ROW_WIDTH-1:0]         r_src;
    logic [ROW_WIDTH-1:0]         r_dst;
    logic                         r_valid;
    logic [AGG_WIDTH-1:0]         r_agg [FEATURE_ROWS][WEIGHT_COLS];
    logic [LABEL_WIDTH-1:0]       r_y [FEATURE_ROWS];
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;
    logic                         r_coo_read_enable;
    logic [COO_ADDRESS_WIDTH-1:0] r_coo_address;
    logic [ROW_WIDTH-1:0]         r_read_row;

    logic [ROW_WIDTH-1:0]   w_src;
    logic [ROW_WIDTH-1:0]   w_dst;
    logic                   w_edge_ok;
    logic                   w_last_edge;
    logic                   w_last_node;
    logic [ROW_WIDTH-1:0]   w_target;
    logic                   w_add_en;
    logic [AGG_WIDTH-1:0]   w_sum [WEIGHT_COLS];
    logic [LABEL_WIDTH-1:0] w_best;
    logic [AGG_WIDTH-1:0]   w_best_val;

    assign w_src       = bus.coo_in[2*ROW_WIDTH-1:ROW_WIDTH];
    assign w_dst       = bus.coo_in[ROW_WIDTH-1:0];
    assign w_edge_ok   = ({1'b0, w_src} < (ROW_WIDTH+1)'(FEATURE_ROWS)) && ({1'b0, w_dst} < (ROW_WIDTH+1)'(FEATURE_ROWS));
    assign w_last_edge = r_edge_idx == COO_ADDRESS_WIDTH'(NUM_EDGES - 1);
    assign w_last_node = r_node == ROW_WIDTH'(FEATURE_ROWS - 1);
    assign w_target    = (r_state == S_ACC_DST) ? r_dst : (r_state == S_ACC_SRC) ? r_src : r_node;
    assign w_add_en    = (r_state == S_ACC_DST && r_valid) ||
                         (r_state == S_ACC_SRC && r_valid && r_src != r_dst) ||
                         (r_state == S_SELF);

    // Row being accumulated plus the incoming product row, wrapping at AGG_WIDTH
    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++)
            w_sum[c] = r_agg[w_target][c] + AGG_WIDTH'(bus.fm_wm_row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
    end

    // Argmax of the current node's accumulator; strict compare keeps the lowest index on ties
    always_comb begin
        w_best     = '0;
        w_best_val = r_agg[r_node][0];
        for (int c = 1; c < WEIGHT_COLS; c++)
            if (r_agg[r_node][c] > w_best_val) begin
                w_best     = LABEL_WIDTH'(c);
                w_best_val = r_agg[r_node][c];
            end
    end

    // Pass sequencer: edge walk, self-loop add, per-node argmax, with registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_edge_idx        <= '0;
            r_node            <= '0;
            r_src             <= '0;
            r_dst             <= '0;
            r_valid           <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_err             <= 1'b0;
            r_coo_read_enable <= 1'b0;
            r_coo_address     <= '0;
            r_read_row        <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                r_y[r] <= '0;
                for (int c = 0; c < WEIGHT_COLS; c++)
                    r_agg[r][c] <= '0;
            end
        end else begin
            if (w_add_en)
                for (int c = 0; c < WEIGHT_COLS; c++)
                    r_agg[w_target][c] <= w_sum[c];
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        for (int r = 0; r < FEATURE_ROWS; r++) begin
                            r_y[r] <= '0;
                            for (int c = 0; c < WEIGHT_COLS; c++)
                                r_agg[r][c] <= '0;
                        end
                        r_err             <= 1'b0;
                        r_done            <= 1'b0;
                        r_busy            <= 1'b1;
                        r_edge_idx        <= '0;
                        r_coo_read_enable <= 1'b1;
                        r_coo_address     <= '0;
                        r_state           <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_src             <= w_src;
                    r_dst             <= w_dst;
                    r_valid           <= w_edge_ok;
                    r_err             <= r_err | ~w_edge_ok;
                    r_coo_read_enable <= 1'b0;
                    r_coo_address     <= '0;
                    r_read_row        <= w_src;
                    r_state           <= S_ACC_DST;
                end
                S_ACC_DST: begin
                    r_read_row <= r_dst;
                    r_state    <= S_ACC_SRC;
                end
                S_ACC_SRC: begin
                    r_read_row <= '0;
                    if (w_last_edge) begin
                        r_node  <= '0;
                        r_state <= S_SELF;
                    end else begin
                        r_edge_idx        <= r_edge_idx + 1'b1;
                        r_coo_read_enable <= 1'b1;
                        r_coo_address     <= r_edge_idx + 1'b1;
                        r_state           <= S_FETCH;
                    end
                end
                S_SELF: begin
                    r_node     <= w_last_node ? '0 : r_node + 1'b1;
                    r_read_row <= w_last_node ? '0 : r_node + 1'b1;
                    r_state    <= w_last_node ? S_ARGMAX : S_SELF;
                end
                S_ARGMAX: begin
                    r_y[r_node] <= w_best;
                    r_node      <= w_last_node ? '0 : r_node + 1'b1;
                    if (w_last_node) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.coo_address     = r_coo_address;
    assign bus.read_row        = r_read_row;
    assign bus.coo_read_enable = r_coo_read_enable;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.coo_error       = r_err;

    for (genvar n = 0; n < FEATURE_ROWS; n++) begin : g_y
        assign bus.y[n*LABEL_WIDTH +: LABEL_WIDTH] = r_y[n];
    end
endmodule

// File: tb/tb_gcn_combination.sv
// tb_gcn_combination: directed and random passes checked against an edge-list reference model
module tb_gcn_combination;
    localparam int FR = 6, WC = 3, NE = 6, DW = 16, AW = 21, CAW = 13, RW = 3, LW = 2;

    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    int rows [FR][WC];
    int es [NE];
    int ed [NE];
    logic [FR*LW-1:0] exp_y;
    logic exp_err;

    gcn_combination_if #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW),
                         .COO_ADDRESS_WIDTH(CAW), .ROW_WIDTH(RW), .LABEL_WIDTH(LW)) bus ();

    gcn_combination #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .NUM_EDGES(NE), .DOT_PROD_WIDTH(DW),
                      .AGG_WIDTH(AW), .COO_ADDRESS_WIDTH(CAW), .ROW_WIDTH(RW), .LABEL_WIDTH(LW))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        bus.coo_in    = '0;
        bus.fm_wm_row = '0;
        for (int e = 0; e < NE; e++)
            if (int'(bus.coo_address) == e) bus.coo_in = {RW'(es[e]), RW'(ed[e])};
        for (int r = 0; r < FR; r++)
            if (int'(bus.read_row) == r)
                for (int c = 0; c < WC; c++) bus.fm_wm_row[c*DW +: DW] = DW'(rows[r][c]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model();
        longint agg [FR][WC];
        longint m;
        int best;
        m = (longint'(1) << AW) - 1;
        exp_err = 1'b0;
        for (int n = 0; n < FR; n++)
            for (int c = 0; c < WC; c++) agg[n][c] = rows[n][c];
        for (int e = 0; e < NE; e++) begin
            if (es[e] < FR && ed[e] < FR) begin
                for (int c = 0; c < WC; c++) begin
                    agg[ed[e]][c] += rows[es[e]][c];
                    if (es[e] != ed[e]) agg[es[e]][c] += rows[ed[e]][c];
                end
            end else exp_err = 1'b1;
        end
        for (int n = 0; n < FR; n++) begin
            best = 0;
            for (int c = 1; c < WC; c++)
                if ((agg[n][c] & m) > (agg[n][best] & m)) best = c;
            exp_y[n*LW +: LW] = LW'(best);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_y"}, 32'(bus.y), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_err"}, 32'(bus.coo_error), 0);
        chk({tag, "_addr"}, 32'(bus.coo_address), 0);
        chk({tag, "_row"}, 32'(bus.read_row), 0);
        chk({tag, "_ren"}, 32'(bus.coo_read_enable), 0);
    endtask

    task automatic run_pass(input string tag, input int pulse_at);
        int lat;
        model();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy0"}, 32'(bus.busy), 1);
        chk({tag, "_done0"}, 32'(bus.done), 0);
        chk({tag, "_ren0"}, 32'(bus.coo_read_enable), 1);
        lat = 0;
        for (int cyc = 1; cyc <= 100 && lat == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) chk({tag, "_rd_src"}, 32'(bus.read_row), es[0]);
            if (cyc == 2) chk({tag, "_rd_dst"}, 32'(bus.read_row), ed[0]);
            if (cyc == 3) chk({tag, "_addr1"}, 32'(bus.coo_address), 1);
            bus.start = (cyc == pulse_at);
            if (bus.done) lat = cyc;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, lat, 30);
        chk({tag, "_y"}, 32'(bus.y), 32'(exp_y));
        chk({tag, "_err"}, 32'(bus.coo_error), 32'(exp_err));
        chk({tag, "_busy_end"}, 32'(bus.busy), 0);
        chk({tag, "_row_end"}, 32'(bus.read_row), 0);
    endtask

    task automatic base_rows();
        rows = '{'{10, 0, 0}, '{0, 20, 0}, '{0, 0, 30}, '{5, 0, 0}, '{0, 5, 0}, '{0, 0, 5}};
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        base_rows();
        es = '{0, 1, 2, 3, 4, 5};
        ed = '{1, 2, 0, 4, 5, 3};
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) reset = 1'b0;

        run_pass("ring", 0);
        chk("ring_const_y", 32'(bus.y), 32'h02A);

        es = '{0, 0, 0, 0, 0, 0};
        ed = '{0, 0, 0, 0, 0, 0};
        run_pass("self", 0);
        chk("self_const_y", 32'(bus.y), 32'h924);

        es = '{0, 7, 2, 3, 4, 5};
        ed = '{1, 1, 0, 4, 5, 3};
        run_pass("bad", 0);
        chk("bad_const_err", 32'(bus.coo_error), 1);

        for (int r = 0; r < FR; r++) rows[r] = '{65535, 65535, 65534};
        es = '{0, 0, 0, 0, 0, 0};
        ed = '{1, 1, 1, 1, 1, 1};
        run_pass("big", 0);

        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < FR; r++)
                for (int c = 0; c < WC; c++)
                    rows[r][c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
            for (int e = 0; e < NE; e++) begin
                es[e] = (k < 4) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 7));
                ed[e] = (k < 4) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 7));
            end
            run_pass($sformatf("rnd%0d", k), 0);
        end

        base_rows();
        es = '{0, 1, 2, 3, 4, 5};
        ed = '{1, 2, 0, 4, 5, 3};
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk) reset = 1'b0;
        run_pass("after_rst", 0);

        run_pass("rs1", 5);
        run_pass("rs2", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
